// File: rtl/ap_com_prog_array_if.sv
// rtl/ap_com_prog_array_if.sv - config, input and output handshake bundle for ap_com_prog_array
//
// Signals (slave = the compressor array):
//   cfg_valid/cfg_ready/cfg_ch/cfg_lut   truth-table write channel
//   in_valid/in_ready/in_data            input vector, lane c at [c*N_IN +: N_IN]
//   out_valid/out_ready/out_y            registered result, bit c = channel c
interface ap_com_prog_array_if #(
  parameter int N_IN = 4,
  parameter int N_CH = 8,
  localparam int LUT_W = 2**N_IN,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch;
  logic [LUT_W-1:0]     cfg_lut;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_CH*N_IN-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [N_CH-1:0]      out_y;

  modport master (
    output cfg_valid, cfg_ch, cfg_lut, in_valid, in_data, out_ready,
    input  cfg_ready, in_ready, out_valid, out_y
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_lut, in_valid, in_data, out_ready,
    output cfg_ready, in_ready, out_valid, out_y
  );
endinterface

// File: rtl/ap_com_prog_array.sv
// rtl/ap_com_prog_array.sv - runtime-programmable approximate-compressor LUT array
//
// Ports:
//   clk     clock, all state on rising edge
//   rst_n   asynchronous active-low reset
//   bus     ap_com_prog_array_if.slave (config write, input vector, registered output)
//   rd_ch   readback channel select   (only with AP_COM_LUT_READBACK_EN)
//   rd_lut  registered readback table (only with AP_COM_LUT_READBACK_EN)
//
// Optional feature macro: AP_COM_LUT_READBACK_EN
module ap_com_prog_array #(
  parameter int          N_IN     = 4,
  parameter int          N_CH     = 8,
  parameter logic [15:0] INIT_LUT = 16'hEEE8,
  localparam int LUT_W = 2**N_IN,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef AP_COM_LUT_READBACK_EN
  input  logic [CH_W-1:0]   rd_ch,
  output logic [LUT_W-1:0]  rd_lut,
`endif
  ap_com_prog_array_if.slave bus
);

  typedef enum logic {IDLE, FULL} state_e;

  state_e           state_q, state_d;
  logic [N_CH-1:0]  out_y_q, out_y_d;
  logic [LUT_W-1:0] lut_q [N_CH];
  logic [N_CH-1:0]  y_eval;
  logic             out_valid;
  logic             cfg_fire;
  logic             in_fire;

  assign out_valid = (state_q == FULL);

  // Config is only accepted with an empty output register so a pending
  // result always matches the table that produced it; config wins over data.
  always_comb begin
    cfg_fire = bus.cfg_valid && !out_valid;
    in_fire  = bus.in_valid && (!out_valid || bus.out_ready) && !cfg_fire;
  end

  assign bus.cfg_ready = !out_valid;
  assign bus.in_ready  = (!out_valid || bus.out_ready) && !cfg_fire;
  assign bus.out_valid = out_valid;
  assign bus.out_y     = out_y_q;

  // Each lane's input vector selects one bit of that channel's truth table.
  always_comb begin
    y_eval = '0;
    for (int c = 0; c < N_CH; c++) begin
      y_eval[c] = lut_q[c][bus.in_data[c*N_IN +: N_IN]];
    end
  end

  always_comb begin
    state_d = state_q;
    out_y_d = out_y_q;
    if (in_fire) begin
      out_y_d = y_eval;
    end
    case (state_q)
      IDLE: begin
        if (in_fire) state_d = FULL;
      end
      FULL: begin
        if (bus.out_ready && !in_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_y_q <= '0;
    end else begin
      state_q <= state_d;
      out_y_q <= out_y_d;
    end
  end

  // Indices at or above N_CH match no channel, so the write is silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        lut_q[c] <= INIT_LUT[LUT_W-1:0];
      end
    end else if (cfg_fire) begin
      for (int c = 0; c < N_CH; c++) begin
        if (bus.cfg_ch == CH_W'(c)) lut_q[c] <= bus.cfg_lut;
      end
    end
  end

`ifdef AP_COM_LUT_READBACK_EN
  logic [LUT_W-1:0] rd_sel;
  logic [LUT_W-1:0] rd_lut_q;

  // Mux built by compare so out-of-range selects read as zero; sampling the
  // pre-edge table gives old data on a same-cycle write.
  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rd_ch == CH_W'(c)) rd_sel = lut_q[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_lut_q <= '0;
    end else begin
      rd_lut_q <= rd_sel;
    end
  end

  assign rd_lut = rd_lut_q;
`endif

endmodule

// File: tb/tb_ap_com_prog_array.sv
// tb/tb_ap_com_prog_array.sv - self-checking bench for ap_com_prog_array
module tb_ap_com_prog_array;

  localparam int N_IN = 4;
  localparam int N_CH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ap_com_prog_array_if #(.N_IN(N_IN), .N_CH(N_CH)) bus8 ();
  ap_com_prog_array_if #(.N_IN(N_IN), .N_CH(5))    bus5 ();

`ifdef AP_COM_LUT_READBACK_EN
  logic [2:0]  rd_ch8, rd_ch5;
  logic [15:0] rd_lut8, rd_lut5;
`endif

  ap_com_prog_array #(.N_IN(N_IN), .N_CH(N_CH), .INIT_LUT(16'hEEE8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef AP_COM_LUT_READBACK_EN
    .rd_ch  (rd_ch8),
    .rd_lut (rd_lut8),
`endif
    .bus    (bus8)
  );

  ap_com_prog_array #(.N_IN(N_IN), .N_CH(5), .INIT_LUT(16'hEEE8)) dut5 (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef AP_COM_LUT_READBACK_EN
    .rd_ch  (rd_ch5),
    .rd_lut (rd_lut5),
`endif
    .bus    (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        cv;
    logic [2:0]  cch;
    logic [15:0] clut;
    logic        iv;
    logic [31:0] idata;
    logic        ordy;
    logic        e_ir;
    logic        e_cr;
    logic        e_ov;
    logic [7:0]  e_y;
  } row_t;

  row_t rows [9];

  // Behavioural reference: tables, output slot contents.
  logic [15:0] m_lut [N_CH];
  logic        m_valid;
  logic [7:0]  m_y;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_eval(input logic [31:0] d);
    logic [7:0] y;
    for (int c = 0; c < N_CH; c++) begin
      int idx;
      idx  = int'(d[c*4 +: 4]);
      y[c] = (((m_lut[c] >> idx) & 16'h1) != 16'h0);
    end
    return y;
  endfunction

  task automatic drive8(input logic cv, input logic [2:0] cch, input logic [15:0] clut,
                        input logic iv, input logic [31:0] idata, input logic ordy);
    bus8.cfg_valid = cv;
    bus8.cfg_ch    = cch;
    bus8.cfg_lut   = clut;
    bus8.in_valid  = iv;
    bus8.in_data   = idata;
    bus8.out_ready = ordy;
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) m_lut[c] = 16'hEEE8;
    m_valid = 1'b0;
    m_y     = 8'h00;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive8(1'b0, 3'd0, 16'h0, 1'b0, 32'h0, 1'b1);
    bus5.cfg_valid = 1'b0;
    bus5.cfg_ch    = '0;
    bus5.cfg_lut   = '0;
    bus5.in_valid  = 1'b0;
    bus5.in_data   = '0;
    bus5.out_ready = 1'b1;
`ifdef AP_COM_LUT_READBACK_EN
    rd_ch8 = 3'd0;
    rd_ch5 = 3'd0;
`endif

    //           cv   cch   clut      iv   idata         ordy ir   cr   ov   y
    rows[0] = '{1'b0, 3'd0, 16'h0000, 1'b1, 32'h33333333, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF};
    rows[1] = '{1'b0, 3'd0, 16'h0000, 1'b1, 32'h88888888, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    rows[2] = '{1'b0, 3'd0, 16'h0000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    rows[3] = '{1'b1, 3'd2, 16'h0001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    rows[4] = '{1'b0, 3'd0, 16'h0000, 1'b1, 32'h55555055, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF};
    rows[5] = '{1'b0, 3'd0, 16'h0000, 1'b1, 32'h55555155, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFB};
    rows[6] = '{1'b0, 3'd0, 16'h0000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    rows[7] = '{1'b1, 3'd0, 16'h0000, 1'b1, 32'h33333333, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    rows[8] = '{1'b0, 3'd0, 16'h0000, 1'b1, 32'h33333333, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFA};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("reset_out_valid", 32'(bus8.out_valid), 32'd0);
    check("reset_out_y", 32'(bus8.out_y), 32'd0);
    check("reset_cfg_ready", 32'(bus8.cfg_ready), 32'd1);
    check("reset_in_ready", 32'(bus8.in_ready), 32'd1);

    // Table-driven directed vectors
    for (int i = 0; i < 9; i++) begin
      drive8(rows[i].cv, rows[i].cch, rows[i].clut, rows[i].iv, rows[i].idata, rows[i].ordy);
      #1;
      check($sformatf("row%0d_in_ready", i), 32'(bus8.in_ready), 32'(rows[i].e_ir));
      check($sformatf("row%0d_cfg_ready", i), 32'(bus8.cfg_ready), 32'(rows[i].e_cr));
      tick();
      check($sformatf("row%0d_out_valid", i), 32'(bus8.out_valid), 32'(rows[i].e_ov));
      if (rows[i].e_ov) check($sformatf("row%0d_out_y", i), 32'(bus8.out_y), 32'(rows[i].e_y));
    end

    // Backpressure: output held FA for five stalled cycles
    drive8(1'b1, 3'd1, 16'h0000, 1'b1, 32'h88888838, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall%0d_in_ready", i), 32'(bus8.in_ready), 32'd0);
      check($sformatf("stall%0d_cfg_ready", i), 32'(bus8.cfg_ready), 32'd0);
      check($sformatf("stall%0d_out_valid", i), 32'(bus8.out_valid), 32'd1);
      check($sformatf("stall%0d_out_y", i), 32'(bus8.out_y), 32'hFA);
      tick();
    end
    drive8(1'b0, 3'd0, 16'h0000, 1'b1, 32'h88888838, 1'b1);
    #1;
    check("release_in_ready", 32'(bus8.in_ready), 32'd1);
    tick();
    check("release_out_valid", 32'(bus8.out_valid), 32'd1);
    check("release_out_y", 32'(bus8.out_y), 32'h02);

    // Async reset while a result is pending
    drive8(1'b0, 3'd0, 16'h0000, 1'b0, 32'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 32'(bus8.out_valid), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    drive8(1'b0, 3'd0, 16'h0000, 1'b1, 32'h33333333, 1'b1);
`ifdef AP_COM_LUT_READBACK_EN
    rd_ch8 = 3'd2;
`endif
    tick();
    check("post_reset_out_valid", 32'(bus8.out_valid), 32'd1);
    check("post_reset_out_y", 32'(bus8.out_y), 32'hFF);
`ifdef AP_COM_LUT_READBACK_EN
    check("post_reset_rd_lut", 32'(rd_lut8), 32'hEEE8);
`endif

    // Out-of-range channel on a 5-channel array
    bus5.cfg_valid = 1'b1;
    bus5.cfg_ch    = 3'd7;
    bus5.cfg_lut   = 16'h0000;
    #1;
    check("oor_cfg_ready", 32'(bus5.cfg_ready), 32'd1);
    check("oor_in_ready", 32'(bus5.in_ready), 32'd0);
    tick();
    bus5.cfg_valid = 1'b0;
    bus5.in_valid  = 1'b1;
    bus5.in_data   = 20'h33333;
`ifdef AP_COM_LUT_READBACK_EN
    rd_ch5 = 3'd7;
`endif
    tick();
    check("oor_out_y", 32'(bus5.out_y), 32'h1F);
`ifdef AP_COM_LUT_READBACK_EN
    check("oor_rd_lut", 32'(rd_lut5), 32'h0);
    rd_ch5 = 3'd0;
`endif
    bus5.in_valid = 1'b0;
    tick();
    bus5.cfg_valid = 1'b1;
    bus5.cfg_ch    = 3'd4;
    tick();
`ifdef AP_COM_LUT_READBACK_EN
    check("ch5_rd_lut0", 32'(rd_lut5), 32'hEEE8);
`endif
    bus5.cfg_valid = 1'b0;
    bus5.in_valid  = 1'b1;
    tick();
    check("ch4_write_out_y", 32'(bus5.out_y), 32'h0F);
    bus5.in_valid = 1'b0;

    // Randomized traffic against the reference model
    drive8(1'b0, 3'd0, 16'h0000, 1'b0, 32'h0, 1'b1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    tick();
    for (int n = 0; n < 400; n++) begin
      logic        cv, iv, ordy, e_cr, e_ir, cfire, ifire;
      logic [2:0]  cch;
      logic [15:0] clut;
      logic [31:0] idata;
`ifdef AP_COM_LUT_READBACK_EN
      logic [15:0] e_rd;
`endif
      cv    = ($urandom_range(0, 3) == 0);
      iv    = ($urandom_range(0, 3) != 0);
      ordy  = ($urandom_range(0, 2) != 0);
      cch   = 3'($urandom_range(0, 7));
      clut  = 16'($urandom());
      idata = $urandom();
      drive8(cv, cch, clut, iv, idata, ordy);
`ifdef AP_COM_LUT_READBACK_EN
      rd_ch8 = 3'($urandom_range(0, 7));
      e_rd   = m_lut[rd_ch8];
`endif
      e_cr  = !m_valid;
      cfire = cv && e_cr;
      e_ir  = (!m_valid || ordy) && !cfire;
      ifire = iv && e_ir;
      #1;
      check("rand_cfg_ready", 32'(bus8.cfg_ready), 32'(e_cr));
      check("rand_in_ready", 32'(bus8.in_ready), 32'(e_ir));
      if (ifire) begin
        m_y     = model_eval(idata);
        m_valid = 1'b1;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
      if (cfire) m_lut[cch] = clut;
      tick();
      check("rand_out_valid", 32'(bus8.out_valid), 32'(m_valid));
      if (m_valid) check("rand_out_y", 32'(bus8.out_y), 32'(m_y));
`ifdef AP_COM_LUT_READBACK_EN
      check("rand_rd_lut", 32'(rd_lut8), 32'(e_rd));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
